// File: rtl/spy_path_sampler.sv
// spy_path_sampler: toggles a delay chain input, captures its output W+1 cycles later and counts in-time arrivals.
// Define SPY_SAMPLER_SYNC_EN to put a second stage behind the capture flop and compare from that stage.
module spy_path_sampler #(
  parameter int TRIALS = 256,
  parameter int WAIT_W = 8,
  parameter int SETTLE = 16,
  parameter bit INVERT = 1'b0,
  localparam int CNT_W = $clog2(TRIALS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              path_input,
  input  logic              path_result,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  hit_count
);

  localparam int SET_W = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] TRIALS_CNT  = CNT_W'(TRIALS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SYNC,
    S_COMPARE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_lat_q, wait_lat_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]  trial_q, trial_d;
  logic [CNT_W-1:0]  hit_q, hit_d;
  logic              path_in_q, path_in_d;
  logic              expect_q, expect_d;
  logic              capture_q, capture_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              accept;
  logic              cmp_bit;

`ifdef SPY_SAMPLER_SYNC_EN
  logic sync_q, sync_d;

  assign sync_d  = capture_q;
  assign cmp_bit = sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
    end
  end
`else
  assign cmp_bit = capture_q;
`endif

  // A finished result may be consumed and replaced by a new start in the same cycle.
  always_comb begin
    accept = 1'b0;
    if (start) begin
      if (state_q == S_IDLE) begin
        accept = 1'b1;
      end else if (state_q == S_DONE && result_ready) begin
        accept = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_lat_d   = wait_lat_q;
    wait_cnt_d   = wait_cnt_q;
    settle_cnt_d = settle_cnt_q;
    trial_d      = trial_q;
    hit_d        = hit_q;
    path_in_d    = path_in_q;
    expect_d     = expect_q;
    capture_d    = capture_q;
    busy_d       = busy_q;
    valid_d      = valid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_LAUNCH: begin
        path_in_d  = ~path_in_q;
        expect_d   = ~path_in_q ^ INVERT;
        wait_cnt_d = wait_lat_q;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_cnt_q == '0) begin
          capture_d = path_result;
`ifdef SPY_SAMPLER_SYNC_EN
          state_d   = S_SYNC;
`else
          state_d   = S_COMPARE;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_SYNC: begin
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (cmp_bit == expect_q) begin
          hit_d = hit_q + CNT_W'(1);
        end
        trial_d = trial_q + CNT_W'(1);
        if (trial_q + CNT_W'(1) == TRIALS_CNT) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          settle_cnt_d = SETTLE_LAST;
          state_d      = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_LAUNCH;
        end else begin
          settle_cnt_d = settle_cnt_q - SET_W'(1);
        end
      end
      S_DONE: begin
        if (result_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      wait_lat_d = wait_cycles;
      trial_d    = '0;
      hit_d      = '0;
      busy_d     = 1'b1;
      valid_d    = 1'b0;
      state_d    = S_LAUNCH;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_lat_q   <= '0;
      wait_cnt_q   <= '0;
      settle_cnt_q <= '0;
      trial_q      <= '0;
      hit_q        <= '0;
      path_in_q    <= 1'b0;
      expect_q     <= 1'b0;
      capture_q    <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_lat_q   <= wait_lat_d;
      wait_cnt_q   <= wait_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      trial_q      <= trial_d;
      hit_q        <= hit_d;
      path_in_q    <= path_in_d;
      expect_q     <= expect_d;
      capture_q    <= capture_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  assign path_input   = path_in_q;
  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign hit_count    = hit_q;

endmodule

// File: tb/tb_spy_path_sampler.sv
// Bench for spy_path_sampler: two instances (INVERT=0/1) share stimulus, each driving its own modelled delay chain.
`timescale 1ns/1ps
module tb_spy_path_sampler;
  localparam int TRIALS = 8;
  localparam int WAIT_W = 8;
  localparam int SETTLE = 2;
  localparam int CNT_W  = $clog2(TRIALS + 1);
`ifdef SPY_SAMPLER_SYNC_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WAIT_W-1:0] wait_cycles;
  logic              result_ready;
  logic              path_input   [2];
  logic              path_result  [2];
  logic              busy         [2];
  logic              result_valid [2];
  logic [CNT_W-1:0]  hit_count    [2];

  int   chain_d   = 0;
  logic chain_inv = 1'b0;
  int   cyc       = 0;
  int   errors    = 0;
  int   checks    = 0;
  logic pin_level = 1'b0;

  typedef struct {
    int   hits0;
    int   hits1;
    logic pin;
    int   done_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  logic rv_prev [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] sr;

    spy_path_sampler #(
      .TRIALS(TRIALS),
      .WAIT_W(WAIT_W),
      .SETTLE(SETTLE),
      .INVERT(g == 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .wait_cycles (wait_cycles),
      .path_input  (path_input[g]),
      .path_result (path_result[g]),
      .busy        (busy[g]),
      .result_valid(result_valid[g]),
      .result_ready(result_ready),
      .hit_count   (hit_count[g])
    );

    // Chain of chain_d clocked stages (0 = plain wire), optionally inverting.
    always @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[2:0], path_input[g]};
    end
    assign path_result[g] = chain_inv ^ ((chain_d == 0) ? path_input[g] : sr[chain_d-1]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // A transition launched into a d-stage chain is seen by a capture W+1 cycles later iff d <= W;
  // otherwise the capture sees the settled level of the previous transition.
  function automatic int ref_hits(input int d, input int w, input logic cinv, input logic inv);
    logic arrived;
    logic match;
    arrived = (d <= w);
    match   = arrived ? (cinv == inv) : (cinv != inv);
    return match ? TRIALS : 0;
  endfunction

  function automatic int ref_latency(input int w);
    int period;
    period = w + 3 + EXTRA + SETTLE;
    return (TRIALS - 1) * period + w + 3 + EXTRA;
  endfunction

  task automatic check_reset_state(input string name);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s_path_input%0d", name, i), path_input[i], 0);
      check($sformatf("%s_busy%0d", name, i), busy[i], 0);
      check($sformatf("%s_result_valid%0d", name, i), result_valid[i], 0);
      check($sformatf("%s_hit_count%0d", name, i), hit_count[i], 0);
    end
  endtask

  task automatic set_chain(input int d, input logic cinv);
    chain_d   = d;
    chain_inv = cinv;
    tick(6);
  endtask

  task automatic launch(input int w);
    exp_t e;
    start       = 1'b1;
    wait_cycles = WAIT_W'(w);
    tick(1);
    start       = 1'b0;
    e.hits0     = ref_hits(chain_d, w, chain_inv, 1'b0);
    e.hits1     = ref_hits(chain_d, w, chain_inv, 1'b1);
    e.pin       = pin_level ^ ((TRIALS % 2) != 0);
    e.done_cyc  = cyc + ref_latency(w);
    pin_level   = e.pin;
    sb_q.push_back(e);
    check("busy_after_start0", busy[0], 1);
    check("busy_after_start1", busy[1], 1);
    wait_cycles = WAIT_W'($urandom);
  endtask

  // Wait for both results, then hold result_ready low for 'hold' cycles while start toggles.
  task automatic finish(input int hold);
    int n;
    n = 0;
    while (!(result_valid[0] && result_valid[1]) && n < 5000) begin
      tick(1);
      n++;
    end
    if (n >= 5000) begin
      errors++;
      checks++;
      $display("FAIL result_timeout: got no result_valid expected one within 5000 cycles");
    end
    for (int k = 0; k < hold; k++) begin
      start = 1'($urandom % 2);
      tick(1);
      check("held_valid0", result_valid[0], 1);
      check("held_busy0", busy[0], 0);
      check("held_hits0", hit_count[0], sb_q.size() > 0 ? sb_q[0].hits0 : -1);
      check("held_hits1", hit_count[1], sb_q.size() > 0 ? sb_q[0].hits1 : -1);
    end
    start = 1'b0;
  endtask

  task automatic release_result();
    result_ready = 1'b1;
    tick(1);
    result_ready = 1'b0;
  endtask

  // Monitor: latency on rising result_valid, contents on the consuming handshake.
  always @(negedge clk) begin
    if (rst) begin
      rv_prev[0] <= 1'b0;
      rv_prev[1] <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (result_valid[i] && !rv_prev[i]) begin
          if (sb_q.size() == 0) check($sformatf("unexpected_valid%0d", i), 1, 0);
          else check($sformatf("latency%0d", i), cyc, sb_q[0].done_cyc);
        end
        rv_prev[i] <= result_valid[i];
      end
      if (result_ready && (result_valid[0] || result_valid[1])) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("hit_count0", hit_count[0], mon_e.hits0);
          check("hit_count1", hit_count[1], mon_e.hits1);
          check("end_path_input0", path_input[0], mon_e.pin);
          check("end_path_input1", path_input[1], mon_e.pin);
          check("valid_pair", result_valid[1], result_valid[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, hold;
    logic cinv;
    int period;
    rst          = 1'b1;
    start        = 1'b0;
    wait_cycles  = '0;
    result_ready = 1'b0;
    tick(3);
    check_reset_state("in_reset");
    rst = 1'b0;
    tick(20);
    check_reset_state("no_start");

    // zero-delay wire chain
    set_chain(0, 1'b0);
    launch(0);
    finish(0);
    release_result();

    // delay boundary with a 3-stage chain
    set_chain(3, 1'b0);
    launch(2);
    finish(0);
    release_result();
    set_chain(3, 1'b0);
    launch(3);
    finish(1);
    release_result();

    // inverting chain
    set_chain(0, 1'b1);
    launch(0);
    finish(0);
    release_result();

    // backpressure then simultaneous consume + start
    set_chain(1, 1'b0);
    launch(1);
    finish(10);
    result_ready = 1'b1;
    launch(4);
    result_ready = 1'b0;
    finish(2);
    release_result();

    // async reset during the WAIT of the third trial
    set_chain(2, 1'b0);
    launch(3);
    period = 3 + 3 + EXTRA + SETTLE;
    tick(2 * period + 3);
    #2 rst = 1'b1;
    sb_q.delete();
    pin_level = 1'b0;
    #1 check_reset_state("async_reset");
    tick(2);
    rst = 1'b0;
    set_chain(2, 1'b0);
    launch(3);
    finish(0);
    release_result();

    // randomized measurements
    for (int it = 0; it < 12; it++) begin
      w    = $urandom_range(0, 5);
      d    = $urandom_range(0, 4);
      cinv = 1'($urandom % 2);
      hold = $urandom_range(0, 3);
      set_chain(d, cinv);
      launch(w);
      finish(hold);
      release_result();
    end

    tick(4);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
